axi_lite_master: RTL and testbench
==================================

// Module: axi_lite_master
// PURPOSE
//  Bridges the core-side request/ready handshake onto a single-outstanding AXI4-Lite master port.
//  Sits directly upstream of axi_slave: its AR/R/AW/W/B channels connect 1:1 to the slave's channels.
//  Accepts one read or write request, drives the AXI channels and returns read data and status.
//  Then signals completion with a one-cycle ready pulse.
// PARAMETERS
//  ADDR_W          32    address width (hs_addr_i, araddr_o, awaddr_o)
//  DATA_W          32    data width; wstrb_o is DATA_W/8 bits
//  TIMEOUT_CYCLES  256   response wait limit, used only when AXI_TIMEOUT_EN is defined
// PORTS
//  clk_i          in   1         clock, all logic on rising edge
//  rst_i          in   1         synchronous active-high reset
//  hs_read_i      in   1         read request, held high until hs_ready_o seen
//  hs_write_i     in   1         write request, held high until hs_ready_o seen
//  hs_addr_i      in   ADDR_W    request address
//  hs_data_i      in   DATA_W    write data
//  byte_select_i  in   DATA_W/8  write byte enables
//  hs_ready_o     out  1         one-cycle completion pulse
//  hs_data_o      out  DATA_W    read data, valid while hs_ready_o=1
//  hs_err_o       out  1         resp!=OKAY (or timeout); valid while hs_ready_o=1
//  arvalid_o/arready_i/araddr_o                       AR channel
//  rvalid_i/rready_o/rdata_i/rresp_i[1:0]             R channel
//  awvalid_o/awready_i/awaddr_o                       AW channel
//  wvalid_o/wready_i/wdata_o/wstrb_o                  W channel
//  bvalid_i/bready_o/bresp_i[1:0]                     B channel
// BEHAVIOUR
//  Reset: state=IDLE; all valid/ready outputs, hs_ready_o, hs_err_o = 0; addr/data/strb/rdata regs = 0.
//  IDLE: hs_read_i has priority over hs_write_i. On a request, latch addr/wdata/strb.
//    Read request -> AR_SEND. Write request -> AW_W_SEND. Nothing is driven on AXI in IDLE.
//  AR_SEND: arvalid_o=1, araddr_o from latch. On arvalid_o&arready_i -> R_WAIT.
//  R_WAIT: rready_o=1. On rvalid_i, latch rdata_i and set err=(rresp_i!=2'b00) -> RESP.
//  AW_W_SEND: awvalid_o and wvalid_o raised in the same cycle. Flags aw_done and w_done set on each handshake.
//    Each valid drops the cycle after its own handshake. Handshakes may occur in either order or together.
//    When both flags are set -> B_WAIT; clear both flags.
//  B_WAIT: bready_o=1. On bvalid_i, set err=(bresp_i!=2'b00) -> RESP.
//  RESP: hs_ready_o=1 for exactly one cycle; hs_data_o and hs_err_o held from latch -> IDLE.
//    The requester deasserts the request in the cycle after RESP.
//    IDLE does not accept a new request in the cycle following RESP: a one-cycle guard state GAP sits between them.
//  Latency with a zero-wait slave: read request -> hs_ready_o 4 cycles; write request -> hs_ready_o 4 cycles.
//  AXI rules: valids are never dropped before their handshake. Addr/data are stable while a valid is high.
//    Valids never depend combinationally on readies. Only one transaction is outstanding at a time.
//  hs_addr_i/hs_data_i changes after latching have no effect. Requests outside IDLE are ignored.
//  rst_i mid-transaction: all outputs return to reset values next cycle; the transaction is abandoned.
// CONFIGURATION
//  AXI_TIMEOUT_EN defined:
//    A counter runs in R_WAIT and B_WAIT. On reaching TIMEOUT_CYCLES: go to RESP with hs_err_o=1 and hs_data_o=0.
//    Then enter DRAIN, keeping rready_o/bready_o=1 until the late rvalid_i/bvalid_i arrives, then -> IDLE.
//    New requests are not accepted while in DRAIN.
//  AXI_TIMEOUT_EN undefined: no counter, no DRAIN state; R_WAIT/B_WAIT wait indefinitely.
// STRUCTURE
//  Package axi_pkg: RESP_OKAY/EXOKAY/SLVERR/DECERR constants and the state encoding localparams.
//    Encoding: IDLE, AR_SEND, R_WAIT, AW_W_SEND, B_WAIT, RESP, GAP, DRAIN.
//  Single module: state register + next-state always block + output always block + datapath regs.
//  The timeout counter stays inline (no sub-module).
// TESTING
//  Read 0x1000 to axi_slave returning 0xDEADBEEF after 3 cycles -> hs_ready_o 1 cycle, hs_data_o=0xDEADBEEF, hs_err_o=0.
//  Write 0x2004 data 0xA5A5A5A5 strb 4'b0011 -> awaddr_o=0x2004, wdata_o=0xA5A5A5A5, wstrb_o=4'b0011.
//    Then one hs_ready_o pulse after bvalid_i.
//  Write with wready_i 3 cycles after awready_i -> awvalid_o drops after its handshake, wvalid_o held until its own.
//    Single B_WAIT follows.
//  hs_read_i and hs_write_i both high -> read performed first, no AW/W activity until read completes.
//  rresp_i=2'b10 -> hs_err_o=1 with hs_ready_o. Assert rst_i during R_WAIT -> rready_o=0, hs_ready_o=0 next cycle.
//  AXI_TIMEOUT_EN, TIMEOUT_CYCLES=8, bvalid_i never asserted -> hs_err_o=1 pulse after 8 cycles, bready_o held.
//    Late bvalid_i drains, next read proceeds normally.

Source files
------------

// File: rtl/axi_pkg.sv
// AXI4-Lite response codes and master FSM state encoding.
// Shared by axi_lite_master and its bench.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] AR_SEND   = 3'd1;
  localparam logic [2:0] R_WAIT    = 3'd2;
  localparam logic [2:0] AW_W_SEND = 3'd3;
  localparam logic [2:0] B_WAIT    = 3'd4;
  localparam logic [2:0] RESP      = 3'd5;
  localparam logic [2:0] GAP       = 3'd6;
  localparam logic [2:0] DRAIN     = 3'd7;

endpackage

// File: rtl/axi_lite_master.sv
// Core request/ready handshake to single-outstanding AXI4-Lite master.
// Ports: clk_i, rst_i (sync, high); hs_* core side; AR/R/AW/W/B AXI side.
// Define AXI_TIMEOUT_EN to add a response timeout (TIMEOUT_CYCLES) and DRAIN.
module axi_lite_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                hs_read_i,
  input  logic                hs_write_i,
  input  logic [ADDR_W-1:0]   hs_addr_i,
  input  logic [DATA_W-1:0]   hs_data_i,
  input  logic [DATA_W/8-1:0] byte_select_i,
  output logic                hs_ready_o,
  output logic [DATA_W-1:0]   hs_data_o,
  output logic                hs_err_o,
  output logic                arvalid_o,
  input  logic                arready_i,
  output logic [ADDR_W-1:0]   araddr_o,
  input  logic                rvalid_i,
  output logic                rready_o,
  input  logic [DATA_W-1:0]   rdata_i,
  input  logic [1:0]          rresp_i,
  output logic                awvalid_o,
  input  logic                awready_i,
  output logic [ADDR_W-1:0]   awaddr_o,
  output logic                wvalid_o,
  input  logic                wready_i,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W/8-1:0] wstrb_o,
  input  logic                bvalid_i,
  output logic                bready_o,
  input  logic [1:0]          bresp_i
);
  import axi_pkg::*;

  logic [2:0]          state, next;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] strb_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic                rd_q;
  logic                aw_done, w_done;
  logic                aw_ok, w_ok;

  // A channel counts as done once its handshake happened, this cycle or earlier.
  assign aw_ok = aw_done | (awvalid_o & awready_i);
  assign w_ok  = w_done  | (wvalid_o  & wready_i);

`ifdef AXI_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic          tmo, to_q;

  assign tmo = (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || !(state == R_WAIT || state == B_WAIT))
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE: begin
        if (hs_read_i)       next = AR_SEND;
        else if (hs_write_i) next = AW_W_SEND;
      end
      AR_SEND:   if (arready_i) next = R_WAIT;
      AW_W_SEND: if (aw_ok && w_ok) next = B_WAIT;
`ifdef AXI_TIMEOUT_EN
      R_WAIT: if (rvalid_i || tmo) next = RESP;
      B_WAIT: if (bvalid_i || tmo) next = RESP;
      RESP:   next = to_q ? DRAIN : GAP;
      DRAIN:  if (rd_q ? rvalid_i : bvalid_i) next = IDLE;
`else
      R_WAIT: if (rvalid_i) next = RESP;
      B_WAIT: if (bvalid_i) next = RESP;
      RESP:   next = GAP;
`endif
      GAP:     next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_comb begin
    arvalid_o  = (state == AR_SEND);
    awvalid_o  = (state == AW_W_SEND) && !aw_done;
    wvalid_o   = (state == AW_W_SEND) && !w_done;
    rready_o   = (state == R_WAIT) || (state == DRAIN && rd_q);
    bready_o   = (state == B_WAIT) || (state == DRAIN && !rd_q);
    hs_ready_o = (state == RESP);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
`ifdef AXI_TIMEOUT_EN
      to_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (hs_read_i || hs_write_i) begin
            addr_q  <= hs_addr_i;
            wdata_q <= hs_data_i;
            strb_q  <= byte_select_i;
            rdata_q <= '0;
            err_q   <= 1'b0;
            rd_q    <= hs_read_i;
`ifdef AXI_TIMEOUT_EN
            to_q    <= 1'b0;
`endif
          end
        end
        R_WAIT: begin
          if (rvalid_i) begin
            rdata_q <= rdata_i;
            err_q   <= (rresp_i != RESP_OKAY);
          end
`ifdef AXI_TIMEOUT_EN
          else if (tmo) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            to_q    <= 1'b1;
          end
`endif
        end
        AW_W_SEND: begin
          if (aw_ok && w_ok) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end else begin
            aw_done <= aw_ok;
            w_done  <= w_ok;
          end
        end
        B_WAIT: begin
          if (bvalid_i) begin
            err_q <= (bresp_i != RESP_OKAY);
          end
`ifdef AXI_TIMEOUT_EN
          else if (tmo) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            to_q    <= 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign araddr_o  = addr_q;
  assign awaddr_o  = addr_q;
  assign wdata_o   = wdata_q;
  assign wstrb_o   = strb_q;
  assign hs_data_o = rdata_q;
  assign hs_err_o  = err_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master acting as its AXI slave.
// Inputs driven and outputs sampled 1ns after each rising edge.
module tb_axi_lite_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hs_read = 1'b0, hs_write = 1'b0;
  logic [31:0] hs_addr = '0, hs_wdata = '0;
  logic [3:0]  bsel = '0;
  logic        hs_ready, hs_err;
  logic [31:0] hs_rdata;
  logic        arvalid, arready = 1'b0;
  logic [31:0] araddr;
  logic        rvalid = 1'b0, rready;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        awvalid, awready = 1'b0;
  logic [31:0] awaddr;
  logic        wvalid, wready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid = 1'b0, bready;
  logic [1:0]  bresp = '0;

  int n_chk  = 0;
  int n_pass = 0;
  int lat;

  axi_lite_master #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .hs_read_i(hs_read), .hs_write_i(hs_write),
    .hs_addr_i(hs_addr), .hs_data_i(hs_wdata),
    .byte_select_i(bsel),
    .hs_ready_o(hs_ready), .hs_data_o(hs_rdata), .hs_err_o(hs_err),
    .arvalid_o(arvalid), .arready_i(arready), .araddr_o(araddr),
    .rvalid_i(rvalid), .rready_o(rready),
    .rdata_i(rdata), .rresp_i(rresp),
    .awvalid_o(awvalid), .awready_i(awready), .awaddr_o(awaddr),
    .wvalid_o(wvalid), .wready_i(wready),
    .wdata_o(wdata), .wstrb_o(wstrb),
    .bvalid_i(bvalid), .bready_o(bready), .bresp_i(bresp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // RESP -> GAP -> IDLE tail; request stays high into GAP.
  task automatic tail(input string tag);
    step();
    check({tag, "_gap_rdy"}, 64'(hs_ready), 64'd0);
    hs_read  = 1'b0;
    hs_write = 1'b0;
    step();
    check({tag, "_idle"}, 64'({arvalid, awvalid, wvalid}), 64'd0);
  endtask

  // Zero-wait slave; latency counted including request cycle.
  task automatic fast(input logic rd, input logic [31:0] d);
    hs_read  = rd;
    hs_write = !rd;
    arready  = 1'b1;
    awready  = 1'b1;
    wready   = 1'b1;
    rvalid   = 1'b1;
    bvalid   = 1'b1;
    rdata    = d;
    rresp    = 2'b00;
    bresp    = 2'b00;
    lat      = 1;
    for (int i = 0; i < 20 && !hs_ready; i++) begin
      step();
      lat++;
    end
    {arready, awready, wready, rvalid, bvalid} = '0;
  endtask

  initial begin
    step();
    step();
    check("rst_ctl", 64'({arvalid, awvalid, wvalid, rready,
                          bready, hs_ready, hs_err}), 64'd0);
    check("rst_addr", 64'({araddr, awaddr}), 64'd0);
    rst = 1'b0;
    step();
    check("rst_data", 64'(hs_rdata), 64'd0);

    // read 0x1000, data 3 cycles after rready
    hs_read = 1'b1;
    hs_addr = 32'h1000;
    step();
    hs_addr = 32'h9999;
    check("rd_arvalid", 64'(arvalid), 64'd1);
    check("rd_araddr", 64'(araddr), 64'h1000);
    arready = 1'b1;
    step();
    arready = 1'b0;
    check("rd_ar_drop", 64'({arvalid, rready}), 64'b01);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rd_wait", 64'({hs_ready, rready}), 64'b01);
    end
    rvalid = 1'b1;
    rdata  = 32'hDEADBEEF;
    step();
    rvalid = 1'b0;
    check("rd_ready", 64'({hs_ready, rready}), 64'b10);
    check("rd_data", 64'(hs_rdata), 64'hDEADBEEF);
    check("rd_err", 64'(hs_err), 64'd0);
    tail("rd");

    // write 0x2004, both channels ready at once
    hs_write = 1'b1;
    hs_addr  = 32'h2004;
    hs_wdata = 32'hA5A5A5A5;
    bsel     = 4'b0011;
    step();
    check("wr_valids", 64'({awvalid, wvalid}), 64'b11);
    check("wr_awaddr", 64'(awaddr), 64'h2004);
    check("wr_wdata", 64'(wdata), 64'hA5A5A5A5);
    check("wr_wstrb", 64'(wstrb), 64'b0011);
    awready = 1'b1;
    wready  = 1'b1;
    step();
    awready = 1'b0;
    wready  = 1'b0;
    check("wr_bwait", 64'({awvalid, wvalid, bready, hs_ready}), 64'b0010);
    step();
    check("wr_bhold", 64'({bready, hs_ready}), 64'b10);
    bvalid = 1'b1;
    step();
    bvalid = 1'b0;
    check("wr_ready", 64'({hs_ready, hs_err}), 64'b10);
    tail("wr");

    // write with wready 3 cycles after awready
    hs_write = 1'b1;
    hs_addr  = 32'h2008;
    step();
    awready = 1'b1;
    step();
    awready = 1'b0;
    check("sk_aw_drop", 64'({awvalid, wvalid}), 64'b01);
    step();
    check("sk_w_hold1", 64'({awvalid, wvalid, bready}), 64'b010);
    step();
    check("sk_w_hold2", 64'({awvalid, wvalid, bready}), 64'b010);
    wready = 1'b1;
    step();
    wready = 1'b0;
    check("sk_bwait", 64'({awvalid, wvalid, bready}), 64'b001);
    bvalid = 1'b1;
    bresp  = 2'b11;
    step();
    bvalid = 1'b0;
    bresp  = 2'b00;
    check("sk_ready", 64'({hs_ready, hs_err}), 64'b11);
    tail("sk");

    // read and write together: read first, no AW/W
    hs_read  = 1'b1;
    hs_write = 1'b1;
    hs_addr  = 32'h3000;
    step();
    check("both_ar", 64'({arvalid, awvalid, wvalid}), 64'b100);
    arready = 1'b1;
    step();
    arready = 1'b0;
    check("both_rwait", 64'({awvalid, wvalid, rready}), 64'b001);
    rvalid = 1'b1;
    rdata  = 32'h0000_0055;
    rresp  = 2'b10;
    step();
    rvalid = 1'b0;
    rresp  = 2'b00;
    check("both_ready", 64'({hs_ready, hs_err, awvalid}), 64'b110);
    check("both_data", 64'(hs_rdata), 64'h55);
    tail("both");

    // zero-wait latency
    fast(1'b1, 32'h1234_5678);
    check("lat_rd", 64'(lat), 64'd4);
    check("lat_rd_data", 64'(hs_rdata), 64'h1234_5678);
    tail("lrd");
    fast(1'b0, 32'h0);
    check("lat_wr", 64'(lat), 64'd4);
    tail("lwr");

    // reset during R_WAIT
    hs_read = 1'b1;
    hs_addr = 32'h4000;
    step();
    arready = 1'b1;
    step();
    arready = 1'b0;
    check("rst_rwait", 64'(rready), 64'd1);
    rst = 1'b1;
    step();
    check("rst_mid", 64'({rready, hs_ready, arvalid}), 64'b000);
    check("rst_mid_addr", 64'(araddr), 64'd0);
    rst     = 1'b0;
    hs_read = 1'b0;
    step();

`ifdef AXI_TIMEOUT_EN
    hs_write = 1'b1;
    hs_addr  = 32'h5000;
    step();
    awready = 1'b1;
    wready  = 1'b1;
    step();
    awready = 1'b0;
    wready  = 1'b0;
    lat = 0;
    for (int i = 0; i < 40 && !hs_ready; i++) begin
      step();
      lat++;
    end
    check("to_cycles", 64'(lat), 64'd8);
    check("to_err", 64'({hs_ready, hs_err}), 64'b11);
    check("to_data", 64'(hs_rdata), 64'd0);
    step();
    hs_write = 1'b0;
    check("to_drain", 64'({bready, hs_ready}), 64'b10);
    step();
    step();
    check("to_drain2", 64'(bready), 64'd1);
    bvalid = 1'b1;
    step();
    bvalid = 1'b0;
    check("to_idle", 64'(bready), 64'd0);
    fast(1'b1, 32'hCAFE_F00D);
    check("to_next_lat", 64'(lat), 64'd4);
    check("to_next", 64'({hs_err, hs_rdata}), {31'd0, 1'b0, 32'hCAFE_F00D});
    tail("tn");
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
